// File: rtl/sweep_pkg.sv
// Shared types and default widths for the triangle sweep sequencer.
// Optional repeat support in sweep_ctrl is enabled with SWEEP_CTRL_REPEAT_EN.
package sweep_pkg;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_DIV_W = 4;
    localparam int DEF_REP_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN,
        FINISH
    } sweep_state_t;

endpackage

// File: rtl/updw_step.sv
// Loadable up/down register holding the current sweep value.
// Load has priority over inc, which has priority over dec.
module updw_step
    import sweep_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Value register: load a new start point or step by one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (inc) begin
            q <= q + WIDTH'(1);
        end else if (dec) begin
            q <= q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/sweep_ctrl.sv
// Triangle sweep sequencer: lo -> hi -> lo with a programmable step rate,
// hold/freeze, a done pulse on completion and an err pulse on a bad range.
// Define SWEEP_CTRL_REPEAT_EN to add the reps port and run reps+1 triangles
// per start without intermediate done pulses.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV_W = DEF_DIV_W,
    parameter int REP_W = DEF_REP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [DIV_W-1:0] div,
`ifdef SWEEP_CTRL_REPEAT_EN
    input  logic [REP_W-1:0] reps,
`endif
    input  logic             hold,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err
);

    sweep_state_t     state;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] presc;

    logic             running;
    logic             tick;
    logic             accept;
    logic             reject;
    logic [WIDTH-1:0] up_next;
    logic [WIDTH-1:0] dn_next;
    logic             up_top;
    logic             dn_bottom;
    logic             reps_left;

    // The sweep only advances in UP/DOWN and only while hold is low, so the
    // prescaler and the tick are both gated by running.
    assign running   = ((state == UP) || (state == DOWN)) && !hold;
    assign tick      = running && (presc == div_q);
    assign accept    = (state == IDLE) && start && (lo < hi);
    assign reject    = (state == IDLE) && start && !(lo < hi);

    // Count stays strictly inside (lo, hi) before a step in the matching
    // direction, so these never wrap when they are actually used.
    assign up_next   = count + WIDTH'(1);
    assign dn_next   = count - WIDTH'(1);
    assign up_top    = (up_next == hi_q);
    assign dn_bottom = (dn_next == lo_q);

`ifdef SWEEP_CTRL_REPEAT_EN
    logic [REP_W-1:0] rep_cnt;

    assign reps_left = (rep_cnt != '0);

    // Remaining extra triangles: loaded on start, consumed at each bottom.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt <= '0;
        end else if (accept) begin
            rep_cnt <= reps;
        end else if ((state == DOWN) && tick && dn_bottom && reps_left) begin
            rep_cnt <= rep_cnt - REP_W'(1);
        end
    end
`else
    // Single-triangle build: the repeat count is permanently zero.
    logic [REP_W-1:0] rep_none;

    assign rep_none  = '0;
    assign reps_left = |rep_none;
`endif

    // Sweep FSM with config latches, prescaler and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            lo_q  <= '0;
            hi_q  <= '0;
            div_q <= '0;
            presc <= '0;
            dir   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lo_q  <= lo;
                        hi_q  <= hi;
                        div_q <= div;
                        presc <= '0;
                        dir   <= 1'b1;
                        busy  <= 1'b1;
                        state <= UP;
                    end else if (reject) begin
                        err <= 1'b1;
                    end
                end
                UP: begin
                    if (running) begin
                        presc <= tick ? '0 : presc + DIV_W'(1);
                    end
                    if (tick && up_top) begin
                        dir   <= 1'b0;
                        state <= DOWN;
                    end
                end
                DOWN: begin
                    if (running) begin
                        presc <= tick ? '0 : presc + DIV_W'(1);
                    end
                    if (tick && dn_bottom) begin
                        if (reps_left) begin
                            dir   <= 1'b1;
                            state <= UP;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    updw_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .clk  (clk),
        .reset(reset),
        .load (accept),
        .inc  ((state == UP) && tick),
        .dec  ((state == DOWN) && tick),
        .d    (lo),
        .q    (count)
    );

endmodule
